// File: rtl/alu_pipe.sv
// Pipelined ALU: one-cycle ops plus an iterative restoring divider.
// Status flags and a BUSY handshake stall the controller during divides.
module alu_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALU_FUN,
  input  logic                  SIGNED,
  input  logic                  Enable,
  output logic                  BUSY,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  OUT_VALID,
  output logic                  ZERO,
  output logic                  CARRY,
  output logic                  OVF,
  output logic                  DIV0
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  if (OUT_WIDTH != 2 * DATA_WIDTH || DATA_WIDTH < 4) begin : g_bad
    $error("alu_pipe: illegal DATA_WIDTH/OUT_WIDTH");
  end

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic           dovf_q, dovf_d;
  logic [2*W-1:0] out_q, out_d;
  logic           vld_q, vld_d;
  logic           cry_q, cry_d;
  logic           ovf_q, ovf_d;
  logic           dz_q, dz_d;

  logic [W:0]     add_u, sub_u, trial;
  logic [2*W-1:0] mul_s, mul_u;
  logic           gt_r, lt_r;
  logic [2*W-1:0] alu_res;
  logic           alu_c, alu_o;

  assign add_u = {1'b0, A} + {1'b0, B};
  assign sub_u = {1'b0, A} - {1'b0, B};
  assign mul_s = {{W{A[W-1]}}, A} * {{W{B[W-1]}}, B};
  assign mul_u = {{W{1'b0}}, A} * {{W{1'b0}}, B};
  assign gt_r  = SIGNED ? ($signed(A) > $signed(B)) : (A > B);
  assign lt_r  = SIGNED ? ($signed(A) < $signed(B)) : (A < B);
  assign trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    unique case (ALU_FUN)
      OP_ADD: begin
        alu_res = SIGNED ? {{W{add_u[W-1]}}, add_u[W-1:0]}
                         : {{(W-1){1'b0}}, add_u};
        alu_c   = add_u[W];
        alu_o   = (A[W-1] == B[W-1]) && (add_u[W-1] != A[W-1]);
      end
      OP_SUB: begin
        alu_res = SIGNED ? {{W{sub_u[W-1]}}, sub_u[W-1:0]}
                         : {{(W-1){1'b0}}, sub_u};
        alu_c   = sub_u[W];
        alu_o   = (A[W-1] != B[W-1]) && (sub_u[W-1] != A[W-1]);
      end
      OP_MUL:  alu_res = SIGNED ? mul_s : mul_u;
      OP_AND:  alu_res = {{W{1'b0}}, A & B};
      OP_OR:   alu_res = {{W{1'b0}}, A | B};
      OP_NAND: alu_res = {{W{1'b0}}, ~(A & B)};
      OP_NOR:  alu_res = {{W{1'b0}}, ~(A | B)};
      OP_XOR:  alu_res = {{W{1'b0}}, A ^ B};
      OP_XNOR: alu_res = {{W{1'b0}}, ~(A ^ B)};
      OP_EQ:   alu_res = {{(2*W-1){1'b0}}, A == B};
      OP_GT:   alu_res = {{(2*W-1){1'b0}}, gt_r};
      OP_LT:   alu_res = {{(2*W-1){1'b0}}, lt_r};
      OP_SHR:  alu_res = {{W{1'b0}}, SIGNED & A[W-1], A[W-1:1]};
      OP_SHL:  alu_res = {{W{1'b0}}, A[W-2:0], 1'b0};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dovf_d  = dovf_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    cry_d   = cry_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (Enable && ALU_FUN == OP_DIV && B == '0) begin
          out_d = {A, {W{1'b1}}};
          vld_d = 1'b1;
          cry_d = 1'b0;
          ovf_d = 1'b0;
          dz_d  = 1'b1;
        end else if (Enable && ALU_FUN == OP_DIV) begin
          state_d = S_DIV;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = A;
          dvs_d   = B;
          negq_d  = SIGNED & (A[W-1] ^ B[W-1]);
          negr_d  = SIGNED & A[W-1];
          dovf_d  = SIGNED && (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
        end else if (Enable && ALU_FUN != OP_NOP) begin
          out_d = alu_res;
          vld_d = 1'b1;
          cry_d = alu_c;
          ovf_d = alu_o;
          dz_d  = 1'b0;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        // first cycle converts the latched operands to magnitudes
        if (cnt_q == '0) begin
          quo_d = negr_q ? -quo_q : quo_q;
          dvs_d = (negq_q ^ negr_q) ? -dvs_q : dvs_q;
        end else begin
          if (!trial[W]) begin
            rem_d = trial[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[W-2:0], quo_q[W-1]};
            quo_d = {quo_q[W-2:0], 1'b0};
          end
          if (cnt_q == CW'(W)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_d   = {negr_q ? -rem_q : rem_q, negq_q ? -quo_q : quo_q};
        vld_d   = 1'b1;
        cry_d   = 1'b0;
        ovf_d   = dovf_q;
        dz_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dovf_q  <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      cry_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dovf_q  <= dovf_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      cry_q   <= cry_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign ALU_OUT   = out_q;
  assign OUT_VALID = vld_q;
  assign ZERO      = (out_q == '0);
  assign CARRY     = cry_q;
  assign OVF       = ovf_q;
  assign DIV0      = dz_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised bench for alu_pipe against an integer-arithmetic model.
// Directed cases first, then a random op stream with idle gaps.
module tb_alu_pipe;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           RST;
  logic [W-1:0]   A, B;
  logic [3:0]     ALU_FUN;
  logic           SIGNED, Enable;
  logic           BUSY, OUT_VALID, ZERO, CARRY, OVF, DIV0;
  logic [2*W-1:0] ALU_OUT;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [15:0] out;
    logic        c;
    logic        o;
    logic        dz;
  } res_t;

  res_t exp_r;

  alu_pipe #(.DATA_WIDTH(W)) dut (
    .clk(clk), .RST(RST), .A(A), .B(B),
    .ALU_FUN(ALU_FUN), .SIGNED(SIGNED), .Enable(Enable),
    .BUSY(BUSY), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .ZERO(ZERO), .CARRY(CARRY), .OVF(OVF), .DIV0(DIV0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] f,
                                 input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic s);
    res_t r;
    int ua, ub, sa, sb, v, q, m;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r.out = '0; r.c = 1'b0; r.o = 1'b0; r.dz = 1'b0;
    case (f)
      4'h0: begin
        v = ua + ub;
        r.c = (v > 255);
        r.o = (sa + sb > 127) || (sa + sb < -128);
        if (s) r.out = 16'(int'($signed(8'(v))));
        else   r.out = 16'(v & 'h1FF);
      end
      4'h1: begin
        v = ua - ub;
        r.c = (ua < ub);
        r.o = (sa - sb > 127) || (sa - sb < -128);
        if (s) r.out = 16'(int'($signed(8'(v))));
        else   r.out = 16'(v & 'h1FF);
      end
      4'h2: r.out = s ? 16'(sa * sb) : 16'(ua * ub);
      4'h3: begin
        if (ub == 0) begin
          r.out = 16'((ua << 8) | 'hFF);
          r.dz = 1'b1;
        end else if (s && sa == -128 && sb == -1) begin
          r.out = 16'h0080;
          r.o = 1'b1;
        end else begin
          q = s ? sa / sb : ua / ub;
          m = s ? sa % sb : ua % ub;
          r.out = 16'(((m & 'hFF) << 8) | (q & 'hFF));
        end
      end
      4'h4: r.out = 16'(ua & ub);
      4'h5: r.out = 16'(ua | ub);
      4'h6: r.out = 16'(~(ua & ub) & 'hFF);
      4'h7: r.out = 16'(~(ua | ub) & 'hFF);
      4'h8: r.out = 16'(ua ^ ub);
      4'h9: r.out = 16'(~(ua ^ ub) & 'hFF);
      4'hA: r.out = 16'(ua == ub);
      4'hB: r.out = s ? 16'(sa > sb) : 16'(ua > ub);
      4'hC: r.out = s ? 16'(sa < sb) : 16'(ua < ub);
      4'hD: r.out = s ? 16'((sa >>> 1) & 'hFF) : 16'(ua >> 1);
      4'hE: r.out = 16'((ua << 1) & 'hFF);
      default: r.out = '0;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_out"}, 32'(ALU_OUT), 32'(exp_r.out));
    check({tag, "_zero"}, 32'(ZERO), 32'(exp_r.out == 16'h0));
    check({tag, "_c"}, 32'(CARRY), 32'(exp_r.c));
    check({tag, "_o"}, 32'(OVF), 32'(exp_r.o));
    check({tag, "_dz"}, 32'(DIV0), 32'(exp_r.dz));
  endtask

  task automatic do_op(input logic [3:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic s);
    res_t r;
    r = model(f, a, b, s);
    A = a; B = b; ALU_FUN = f; SIGNED = s; Enable = 1'b1;
    step();
    if (f == 4'hF) begin
      Enable = 1'b0;
      check("nop_vld", 32'(OUT_VALID), 0);
      check_outs("nop_hold");
      return;
    end
    if (f == 4'h3 && b != 8'h0) begin
      for (int k = 0; k <= W + 1; k++) begin
        check("div_busy", 32'(BUSY), 1);
        check("div_vld", 32'(OUT_VALID), 0);
        Enable = 1'($urandom_range(0, 1));
        A = 8'($urandom);
        B = 8'($urandom);
        ALU_FUN = 4'($urandom);
        SIGNED = 1'($urandom);
        step();
      end
    end
    Enable = 1'b0;
    exp_r = r;
    check("op_vld", 32'(OUT_VALID), 1);
    check("op_busy", 32'(BUSY), 0);
    check_outs("op");
  endtask

  task automatic idle();
    Enable = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    ALU_FUN = 4'($urandom);
    step();
    check("idle_vld", 32'(OUT_VALID), 0);
    check("idle_busy", 32'(BUSY), 0);
    check_outs("idle");
  endtask

  initial begin
    RST = 1'b1; Enable = 1'b0; A = '0; B = '0;
    ALU_FUN = 4'h0; SIGNED = 1'b0;
    exp_r = '{out: 16'h0, c: 1'b0, o: 1'b0, dz: 1'b0};
    step();
    step();
    check("rst_vld", 32'(OUT_VALID), 0);
    check("rst_busy", 32'(BUSY), 0);
    check_outs("rst");
    RST = 1'b0;

    do_op(4'h0, 8'd200, 8'd100, 1'b0);
    check("tp_add", 32'(ALU_OUT), 32'h012C);
    idle();
    do_op(4'h0, 8'h7F, 8'h01, 1'b1);
    check("tp_add_s", 32'(ALU_OUT), 32'hFF80);
    do_op(4'h1, 8'd5, 8'd5, 1'b1);
    check("tp_sub_z", 32'(ZERO), 1);
    do_op(4'h2, 8'hFD, 8'd7, 1'b1);
    check("tp_mul_s", 32'(ALU_OUT), 32'hFFEB);
    do_op(4'h2, 8'hFD, 8'd7, 1'b0);
    check("tp_mul_u", 32'(ALU_OUT), 32'h06EB);
    do_op(4'h3, 8'd200, 8'd7, 1'b0);
    check("tp_div_u", 32'(ALU_OUT), 32'h041C);
    idle();
    do_op(4'h3, 8'hF9, 8'd2, 1'b1);
    check("tp_div_s", 32'(ALU_OUT), 32'hFFFD);
    do_op(4'h3, 8'h80, 8'hFF, 1'b1);
    check("tp_div_ovf", 32'(ALU_OUT), 32'h0080);
    do_op(4'h3, 8'h5A, 8'h00, 1'b0);
    check("tp_div0", 32'(ALU_OUT), 32'h5AFF);
    do_op(4'hF, 8'h12, 8'h34, 1'b0);
    idle();

    A = 8'd200; B = 8'd7; ALU_FUN = 4'h3; SIGNED = 1'b0; Enable = 1'b1;
    step();
    Enable = 1'b0;
    for (int k = 1; k < 4; k++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_r = '{out: 16'h0, c: 1'b0, o: 1'b0, dz: 1'b0};
    check("abort_busy", 32'(BUSY), 0);
    check("abort_vld", 32'(OUT_VALID), 0);
    check_outs("abort");
    do_op(4'h0, 8'd3, 8'd4, 1'b0);
    for (int k = 0; k < W + 2; k++) idle();

    for (int i = 0; i < 300; i++) begin
      logic [3:0] f;
      logic [7:0] a, b;
      f = 4'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) idle();
      else do_op(f, a, b, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
